// File: rtl/btn_event_decoder_pkg.sv
// btn_event_decoder_pkg: FSM state encodings and default tick constants for a 50 MHz
// board clock, shared by button event consumers.
package btn_event_decoder_pkg;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_PRESSED = 3'd1,
      ST_LONG    = 3'd2,
      ST_WAIT_DC = 3'd3,
      ST_SECOND  = 3'd4
   } state_e;

   localparam int DEF_CNT_W        = 16;
   localparam int DEF_LONG_TICKS   = 50000;
   localparam int DEF_DCLICK_TICKS = 25000;
   localparam int DEF_REPEAT_TICKS = 10000;

   // A tick bound must fit the counter and leave room for the terminal compare at ticks-1.
   function automatic bit ticks_ok(input int ticks, input int cnt_w);
      return (ticks >= 2) && (ticks < (1 << cnt_w));
   endfunction

endpackage

// File: rtl/btn_sync2.sv
// btn_sync2: two-flop synchroniser with asynchronous active-low reset, for any
// asynchronous single-bit input.
module btn_sync2 (
   input  logic clockSource,
   input  logic resetN,
   input  logic d,
   output logic q
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clockSource or negedge resetN) begin
      if (!resetN) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/btn_event_decoder.sv
// btn_event_decoder: turns a debounced button level into single-cycle short/long/double-click
// events; define AUTO_REPEAT_EN to add a periodic repeat pulse while a long press is held.
module btn_event_decoder
   import btn_event_decoder_pkg::*;
#(
   parameter int CNT_W        = DEF_CNT_W,
   parameter int LONG_TICKS   = DEF_LONG_TICKS,
   parameter int DCLICK_TICKS = DEF_DCLICK_TICKS,
   parameter int REPEAT_TICKS = DEF_REPEAT_TICKS
) (
   input  logic clockSource,
   input  logic resetN,
   input  logic btnLevel,
   output logic held,
   output logic shortPress,
   output logic longPress,
   output logic doubleClick,
   output logic repeatPulse
);

   if (!ticks_ok(LONG_TICKS, CNT_W) || !ticks_ok(DCLICK_TICKS, CNT_W) ||
       !ticks_ok(REPEAT_TICKS, CNT_W)) begin : g_bad_ticks
      $error("btn_event_decoder: every *_TICKS must be >= 2 and < 2**CNT_W");
   end

   localparam logic [CNT_W-1:0] LONG_LIM   = CNT_W'(LONG_TICKS - 1);
   localparam logic [CNT_W-1:0] DCLICK_LIM = CNT_W'(DCLICK_TICKS - 1);
`ifdef AUTO_REPEAT_EN
   localparam logic [CNT_W-1:0] REPEAT_LIM = CNT_W'(REPEAT_TICKS - 1);
`endif

   logic             lvl;
   logic             lvl_prev_q;
   logic             rise;
   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
   logic             short_q, short_d;
   logic             long_q, long_d;
   logic             dc_q, dc_d;
   logic             rep_q, rep_d;

   btn_sync2 u_sync (
      .clockSource (clockSource),
      .resetN      (resetN),
      .d           (btnLevel),
      .q           (lvl)
   );

   // lvl_prev_q starts at 0, so a button held through reset release reads as a fresh press.
   assign rise    = lvl & ~lvl_prev_q;
   assign cnt_inc = cnt_q + CNT_W'(1);

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      short_d = 1'b0;
      long_d  = 1'b0;
      dc_d    = 1'b0;
      rep_d   = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (rise) state_d = ST_PRESSED;
         end
         ST_PRESSED: begin
            cnt_d = cnt_inc;
            if (!lvl) begin
               state_d = ST_WAIT_DC;
            end else if (cnt_q == LONG_LIM) begin
               long_d  = 1'b1;
               state_d = ST_LONG;
            end
         end
         ST_LONG: begin
            if (!lvl) begin
               state_d = ST_IDLE;
            end
`ifdef AUTO_REPEAT_EN
            else if (cnt_q == REPEAT_LIM) begin
               rep_d = 1'b1;
               cnt_d = '0;
            end else begin
               cnt_d = cnt_inc;
            end
`endif
         end
         ST_WAIT_DC: begin
            cnt_d = cnt_inc;
            if (rise) begin
               dc_d    = 1'b1;
               state_d = ST_SECOND;
            end else if (cnt_q == DCLICK_LIM) begin
               short_d = 1'b1;
               state_d = ST_IDLE;
            end
         end
         ST_SECOND: begin
            if (!lvl) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
      if (state_d != state_q) cnt_d = '0;
   end

   always_ff @(posedge clockSource or negedge resetN) begin
      if (!resetN) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         lvl_prev_q <= 1'b0;
         short_q    <= 1'b0;
         long_q     <= 1'b0;
         dc_q       <= 1'b0;
         rep_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         lvl_prev_q <= lvl;
         short_q    <= short_d;
         long_q     <= long_d;
         dc_q       <= dc_d;
         rep_q      <= rep_d;
      end
   end

   assign held        = lvl;
   assign shortPress  = short_q;
   assign longPress   = long_q;
   assign doubleClick = dc_q;
   assign repeatPulse = rep_q;

endmodule

// File: tb/tb_btn_event_decoder.sv
// tb_btn_event_decoder: directed and randomized button sequences checked cycle by cycle
// against a timestamp-based event model; honours AUTO_REPEAT_EN.
module tb_btn_event_decoder;

   localparam int CNT_W = 4;
   localparam int LONG  = 8;
   localparam int DCLK  = 6;
   localparam int REP   = 4;

   localparam int P_IDLE   = 0;
   localparam int P_FIRST  = 1;
   localparam int P_LONG   = 2;
   localparam int P_GAP    = 3;
   localparam int P_SECOND = 4;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic btn = 1'b0;
   logic held, sp, lp, dc, rp;

   btn_event_decoder #(
      .CNT_W        (CNT_W),
      .LONG_TICKS   (LONG),
      .DCLICK_TICKS (DCLK),
      .REPEAT_TICKS (REP)
   ) dut (
      .clockSource (clk),
      .resetN      (rst_n),
      .btnLevel    (btn),
      .held        (held),
      .shortPress  (sp),
      .longPress   (lp),
      .doubleClick (dc),
      .repeatPulse (rp)
   );

   always #5 clk = ~clk;

   int n_chk = 0;
   int n_pass = 0;
   int cyc = 0;
   int t0 = 0;
   bit d1, d2, d3;
   int phase = P_IDLE;
   int t_mark = 0;
   bit e_short, e_long, e_dc, e_rep, e_held;
   int n_short, n_long, n_dc, n_rep;
   int at_short, at_long, at_dc;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s @cycle %0d: got %0d expected %0d", tag, cyc, got, exp);
   endtask

   task automatic model_reset();
      d1 = 0; d2 = 0; d3 = 0;
      phase = P_IDLE;
      {e_short, e_long, e_dc, e_rep, e_held} = '0;
   endtask

   // Events follow from how long the synchronised level has been in each phase.
   task automatic model_edge();
      bit lv, rs;
      lv = d2;
      rs = d2 & ~d3;
      {e_short, e_long, e_dc, e_rep} = '0;
      case (phase)
         P_IDLE:   if (rs) begin phase = P_FIRST; t_mark = cyc; end
         P_FIRST:  if (!lv) begin phase = P_GAP; t_mark = cyc; end
                   else if (cyc - t_mark == LONG) begin e_long = 1; phase = P_LONG; t_mark = cyc; end
         P_LONG:   if (!lv) phase = P_IDLE;
`ifdef AUTO_REPEAT_EN
                   else if (cyc - t_mark == REP) begin e_rep = 1; t_mark = cyc; end
`endif
         P_GAP:    if (rs) begin e_dc = 1; phase = P_SECOND; end
                   else if (cyc - t_mark == DCLK) begin e_short = 1; phase = P_IDLE; end
         P_SECOND: if (!lv) phase = P_IDLE;
         default:  phase = P_IDLE;
      endcase
      d3 = d2; d2 = d1; d1 = btn;
      e_held = d2;
   endtask

   task automatic check_outputs();
      check("held", held, e_held);
      check("shortPress", sp, e_short);
      check("longPress", lp, e_long);
      check("doubleClick", dc, e_dc);
      check("repeatPulse", rp, e_rep);
   endtask

   task automatic step();
      @(posedge clk);
      cyc++;
      if (!rst_n) model_reset();
      else model_edge();
      #1;
      check_outputs();
      if (sp) begin n_short++; at_short = cyc; end
      if (lp) begin n_long++; at_long = cyc; end
      if (dc) begin n_dc++; at_dc = cyc; end
      if (rp) n_rep++;
   endtask

   task automatic hold(input logic v, input int n);
      btn = v;
      repeat (n) step();
   endtask

   task automatic clr();
      n_short = 0; n_long = 0; n_dc = 0; n_rep = 0;
      at_short = -1; at_long = -1; at_dc = -1;
      t0 = cyc + 1;
   endtask

   task automatic do_reset(input int n);
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outputs();
      repeat (n) step();
      rst_n = 1'b1;
   endtask

   initial begin
      clr();
      do_reset(3);
      hold(0, 5);

      clr(); hold(1, 3); hold(0, 20);
      check("t1_short_cnt", n_short, 1);
      check("t1_short_at", at_short - t0, 11);
      check("t1_other_cnt", n_long + n_dc + n_rep, 0);

      clr(); hold(1, 20); hold(0, 10);
      check("t2_long_cnt", n_long, 1);
      check("t2_long_at", at_long - t0, 10);
      check("t2_short_cnt", n_short, 0);
`ifdef AUTO_REPEAT_EN
      check("t2_rep_cnt", n_rep, 2);
`else
      check("t2_rep_cnt", n_rep, 0);
`endif

      clr(); hold(1, 3); hold(0, 2); hold(1, 20); hold(0, 12);
      check("t3_dc_cnt", n_dc, 1);
      check("t3_dc_at", at_dc - t0, 7);
      check("t3_short_long", n_short + n_long, 0);

      clr(); hold(1, 3); hold(0, 6); hold(1, 3); hold(0, 12);
      check("t4_dc_edge_cnt", n_dc, 1);
      check("t4_dc_edge_at", at_dc - t0, 11);
      check("t4_dc_edge_short", n_short, 0);

      clr(); hold(1, 8); hold(0, 20);
      check("t4_rel_thr_long", n_long, 0);
      check("t4_rel_thr_short", n_short, 1);
      check("t4_rel_thr_at", at_short - t0, 16);

      clr(); hold(1, 9); hold(0, 20);
      check("t4_thr_long", n_long, 1);
      check("t4_thr_short", n_short, 0);

      clr(); hold(1, 4); btn = 1'b0; do_reset(3); hold(0, 20);
      check("t5_mid_pressed", n_short + n_long + n_dc + n_rep, 0);
      clr(); hold(1, 3); hold(0, 4); do_reset(3); hold(0, 20);
      check("t5_mid_wait_dc", n_short + n_long + n_dc + n_rep, 0);
      btn = 1'b1; do_reset(3);
      clr(); hold(1, 15); hold(0, 10);
      check("t5_held_long_cnt", n_long, 1);
      check("t5_held_long_at", at_long - t0, 10);

      clr(); hold(1, 40); hold(0, 10);
      check("t6_long_cnt", n_long, 1);
`ifdef AUTO_REPEAT_EN
      check("t6_rep_cnt", n_rep, 7);
`else
      check("t6_rep_cnt", n_rep, 0);
`endif

      for (int i = 0; i < 80; i++) begin
         hold(1, $urandom_range(1, 12));
         if ($urandom_range(0, 15) == 0) do_reset($urandom_range(1, 3));
         hold(0, $urandom_range(1, 10));
      end
      hold(0, 20);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
